neuron_accumulator: RTL and testbench

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

---
 rtl/accel_pkg.sv | 17 +
 rtl/sat_adder.sv | 34 +++
 rtl/neuron_accumulator.sv | 153 +++++++++++++++
 tb/tb_neuron_accumulator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared FSM encoding and width defaults for the neuron accumulator
// Contents:
//    ACC_BITS_DEFAULT  default signed accumulator / result width
//    LEN_BITS_DEFAULT  default width of the term-count and neuron-count fields
//    acc_state_t       layer FSM state encoding (IDLE, ACCUM, DRAIN)
package accel_pkg;

   localparam int ACC_BITS_DEFAULT = 36;
   localparam int LEN_BITS_DEFAULT = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } acc_state_t;

endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - signed accumulator plus signed addend, saturating to the accumulator range
// Ports:
//    i_acc   [ACC_BITS-1:0]  signed running sum
//    i_add   [IN_BITS-1:0]   signed addend, sign-extended internally
//    o_sum   [ACC_BITS-1:0]  saturated sum
//    o_clip                  high when the true sum lay outside the accumulator range
module sat_adder #(
   parameter int IN_BITS  = 27,
   parameter int ACC_BITS = 36
) (
   input  logic signed [ACC_BITS-1:0] i_acc,
   input  logic signed [IN_BITS-1:0]  i_add,
   output logic signed [ACC_BITS-1:0] o_sum,
   output logic                       o_clip
);

   // One guard bit is enough: |i_add| is always below the accumulator range.
   localparam int W = ACC_BITS + 1;
   localparam logic [ACC_BITS-1:0] SAT_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
   localparam logic [ACC_BITS-1:0] SAT_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

   logic [W-1:0] w_acc_ext;
   logic [W-1:0] w_add_ext;
   logic [W-1:0] w_raw;

   assign w_acc_ext = {i_acc[ACC_BITS-1], i_acc};
   assign w_add_ext = {{(W-IN_BITS){i_add[IN_BITS-1]}}, i_add};
   assign w_raw     = w_acc_ext + w_add_ext;

   // Guard bit disagreeing with the result sign bit means the sum left the range.
   assign o_clip = w_raw[W-1] ^ w_raw[W-2];
   assign o_sum  = o_clip ? (w_raw[W-1] ? SAT_MIN : SAT_MAX) : w_raw[ACC_BITS-1:0];

endmodule

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - per-neuron saturating sum of streamed products for one layer
// Ports:
//    clk_pll, rst_n       clock, asynchronous active-low reset
//    start                layer start pulse (honoured in IDLE with nonzero terms/neurons)
//    terms, neurons       products per neuron, neurons per layer (sampled on start)
//    in_data, in_valid    signed product stream, no backpressure
//    out_data, out_valid, out_ready   neuron result handshake
//    busy, done           layer active, one-cycle end-of-layer pulse
//    overrun, sat         sticky result-lost and saturation flags
module neuron_accumulator
   import accel_pkg::*;
#(
   parameter int NUM_OF_BITS = 27,
   parameter int ACC_BITS    = ACC_BITS_DEFAULT,
   parameter int LEN_BITS    = LEN_BITS_DEFAULT
) (
   input  logic                       clk_pll,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [LEN_BITS-1:0]        terms,
   input  logic [LEN_BITS-1:0]        neurons,
   input  logic signed [NUM_OF_BITS-1:0] in_data,
   input  logic                       in_valid,
   output logic signed [ACC_BITS-1:0] out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done,
   output logic                       overrun,
   output logic                       sat
);

   acc_state_t r_state;
   acc_state_t w_state_next;

   logic [LEN_BITS-1:0]        r_terms;
   logic [LEN_BITS-1:0]        r_neurons;
   logic [LEN_BITS-1:0]        r_term_cnt;
   logic [LEN_BITS-1:0]        r_neuron_cnt;
   logic signed [ACC_BITS-1:0] r_acc;
   logic signed [ACC_BITS-1:0] r_out_data;
   logic                       r_out_valid;
   logic                       r_done;
   logic                       r_overrun;
   logic                       r_sat;

   logic signed [ACC_BITS-1:0] w_sum;
   logic w_clip;
   logic w_start_ok;
   logic w_prod;
   logic w_last_term;
   logic w_last_neuron;
   logic w_xfer;
   logic w_drain_exit;

   sat_adder #(
      .IN_BITS  (NUM_OF_BITS),
      .ACC_BITS (ACC_BITS)
   ) u_sat_adder (
      .i_acc  (r_acc),
      .i_add  (in_data),
      .o_sum  (w_sum),
      .o_clip (w_clip)
   );

   assign w_start_ok    = (r_state == ST_IDLE) && start && (terms != '0) && (neurons != '0);
   assign w_prod        = (r_state == ST_ACCUM) && in_valid;
   // Counters run 0..count-1, so a full-scale count never wraps.
   assign w_last_term   = w_prod && (r_term_cnt == r_terms - LEN_BITS'(1));
   assign w_last_neuron = (r_neuron_cnt == r_neurons - LEN_BITS'(1));
   assign w_xfer        = r_out_valid && out_ready;
   assign w_drain_exit  = (r_state == ST_DRAIN) && (!r_out_valid || out_ready);

   // State register
   always_ff @(posedge clk_pll or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_ok) w_state_next = ST_ACCUM;
         ST_ACCUM: if (w_last_term && w_last_neuron) w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_drain_exit) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy      = (r_state != ST_IDLE);
      done      = r_done;
      out_data  = r_out_data;
      out_valid = r_out_valid;
      overrun   = r_overrun;
      sat       = r_sat;
   end

   // Datapath: accumulator, counters, result register and sticky flags
   always_ff @(posedge clk_pll or negedge rst_n) begin
      if (!rst_n) begin
         r_terms      <= '0;
         r_neurons    <= '0;
         r_term_cnt   <= '0;
         r_neuron_cnt <= '0;
         r_acc        <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_done       <= 1'b0;
         r_overrun    <= 1'b0;
         r_sat        <= 1'b0;
      end else begin
         r_done <= w_drain_exit;

         if (w_start_ok) begin
            r_terms      <= terms;
            r_neurons    <= neurons;
            r_acc        <= '0;
            r_term_cnt   <= '0;
            r_neuron_cnt <= '0;
            r_overrun    <= 1'b0;
            r_sat        <= 1'b0;
         end else if (w_prod) begin
            if (w_clip) r_sat <= 1'b1;
            if (w_last_term) begin
               // Clear now so the next product starts a fresh neuron without a bubble.
               r_acc        <= '0;
               r_term_cnt   <= '0;
               r_neuron_cnt <= r_neuron_cnt + LEN_BITS'(1);
            end else begin
               r_acc      <= w_sum;
               r_term_cnt <= r_term_cnt + LEN_BITS'(1);
            end
         end

         // A new result always wins over a same-edge transfer; it only counts
         // as lost when the held result was never taken.
         if (w_last_term) begin
            r_out_data  <= w_sum;
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_ready) r_overrun <= 1'b1;
         end else if (w_xfer) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - directed scoreboard bench for neuron_accumulator
module tb_neuron_accumulator;
   import accel_pkg::*;

   localparam int NB  = 27;
   localparam int AB  = 36;
   localparam int AB2 = 28;
   localparam int LB  = 10;

   logic clk_pll = 1'b0;
   logic rst_n;
   logic start, start2;
   logic [LB-1:0] terms, neurons;
   logic signed [NB-1:0] in_data;
   logic in_valid;
   logic out_ready;

   logic signed [AB-1:0]  out_data;
   logic signed [AB2-1:0] out_data2;
   logic out_valid, busy, done, overrun, sat;
   logic out_valid2, busy2, done2, overrun2, sat2;

   int checks   = 0;
   int failures = 0;
   longint q1[$];
   longint q2[$];

   always #5 clk_pll = ~clk_pll;

   neuron_accumulator #(.NUM_OF_BITS(NB), .ACC_BITS(AB), .LEN_BITS(LB)) dut (
      .clk_pll(clk_pll), .rst_n(rst_n), .start(start), .terms(terms), .neurons(neurons),
      .in_data(in_data), .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .overrun(overrun), .sat(sat)
   );

   neuron_accumulator #(.NUM_OF_BITS(NB), .ACC_BITS(AB2), .LEN_BITS(LB)) dut_sat (
      .clk_pll(clk_pll), .rst_n(rst_n), .start(start2), .terms(terms), .neurons(neurons),
      .in_data(in_data), .in_valid(in_valid), .out_data(out_data2), .out_valid(out_valid2),
      .out_ready(out_ready), .busy(busy2), .done(done2), .overrun(overrun2), .sat(sat2)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_pll);
      #1;
   endtask

   task automatic put(input logic v, input longint d);
      in_valid = v;
      in_data  = NB'(d);
      cycle();
   endtask

   task automatic start_layer(input int which, input int t, input int n);
      terms   = LB'(t);
      neurons = LB'(n);
      if (which == 1) start = 1'b1; else start2 = 1'b1;
      cycle();
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic wait_done(input int which, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (((which == 1) ? done : done2) === 1'b1) begin
            seen = 1'b1;
            break;
         end
         cycle();
      end
      chk({tag, "_done_seen"}, seen, 1);
      cycle();
      chk({tag, "_done_one_cycle"}, (which == 1) ? done : done2, 0);
      chk({tag, "_busy_low"}, (which == 1) ? busy : busy2, 0);
   endtask

   // Scoreboard: every accepted result is compared against the oldest expectation.
   always @(negedge clk_pll) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         chk("dut_sb_expected_pending", q1.size() > 0, 1);
         if (q1.size() > 0) chk("dut_out_data", $signed(out_data), q1.pop_front());
      end
      if (rst_n === 1'b1 && out_valid2 === 1'b1 && out_ready === 1'b1) begin
         chk("sat_sb_expected_pending", q2.size() > 0, 1);
         if (q2.size() > 0) chk("sat_out_data", $signed(out_data2), q2.pop_front());
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; terms = '0; neurons = '0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      cycle(); cycle();
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", $signed(out_data), 0);
      chk("rst_done", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_sat", sat, 0);
      rst_n = 1'b1;
      cycle();

      // Two neurons of three terms, continuous products, always ready
      start_layer(1, 3, 2);
      chk("t1_busy", busy, 1);
      put(1, 1); put(1, 2); q1.push_back(6); put(1, 3);
      put(1, 4); put(1, 5); q1.push_back(15); put(1, 6);
      in_valid = 1'b0;
      chk("t1_last_valid", out_valid, 1);
      chk("t1_no_early_done", done, 0);
      cycle();
      chk("t1_done_latency", done, 1);
      wait_done(1, "t1");
      chk("t1_sb_empty", q1.size(), 0);

      // Negative products, a gap, and an ignored start during ACCUM
      start_layer(1, 4, 1);
      put(1, -5); put(1, 2);
      start = 1'b1; terms = LB'(1); neurons = LB'(1);
      put(0, 77);
      start = 1'b0;
      put(1, -1); q1.push_back(-7); put(1, -3);
      in_valid = 1'b0;
      wait_done(1, "t2");
      chk("t2_sat", sat, 0);
      chk("t2_sb_empty", q1.size(), 0);

      // Consumer stalled: newer result replaces older one, overrun raised
      out_ready = 1'b0;
      start_layer(1, 2, 2);
      put(1, 1); put(1, 2); put(1, 3); q1.push_back(7); put(1, 4);
      in_valid = 1'b0;
      cycle(); cycle(); cycle();
      chk("t3_busy_in_drain", busy, 1);
      chk("t3_out_valid_held", out_valid, 1);
      chk("t3_out_data_newest", $signed(out_data), 7);
      chk("t3_overrun", overrun, 1);
      chk("t3_no_done", done, 0);
      out_ready = 1'b1;
      wait_done(1, "t3");
      chk("t3_overrun_sticky", overrun, 1);
      chk("t3_sb_empty", q1.size(), 0);

      // One term per neuron: a result every cycle, load and transfer together
      start_layer(1, 1, 4);
      chk("t4_overrun_cleared", overrun, 0);
      q1.push_back(10); put(1, 10);
      q1.push_back(-20); put(1, -20);
      q1.push_back(30); put(1, 30);
      q1.push_back(-40); put(1, -40);
      in_valid = 1'b0;
      wait_done(1, "t4");
      chk("t4_overrun", overrun, 0);
      chk("t4_sb_empty", q1.size(), 0);

      // Saturation on a 28-bit accumulator, both directions
      start_layer(2, 3, 2);
      put(1, 67108863); put(1, 67108863); q2.push_back(134217727); put(1, 67108863);
      put(1, -67108864); put(1, -67108864); q2.push_back(-134217728); put(1, -67108864);
      in_valid = 1'b0;
      wait_done(2, "t5");
      chk("t5_sat", sat2, 1);
      chk("t5_overrun", overrun2, 0);
      chk("t5_sb_empty", q2.size(), 0);

      // Full-scale term count and full-scale neuron count
      start_layer(1, 1023, 1);
      for (int i = 0; i < 1023; i++) begin
         if (i == 1022) q1.push_back(1023);
         put(1, 1);
      end
      in_valid = 1'b0;
      wait_done(1, "t6a");
      start_layer(1, 1, 1023);
      for (int i = 0; i < 1023; i++) begin
         q1.push_back(longint'(i % 7) - 3);
         put(1, longint'(i % 7) - 3);
      end
      in_valid = 1'b0;
      wait_done(1, "t6b");
      chk("t6_sb_empty", q1.size(), 0);

      // Reset mid-neuron, then a start on the first cycle after release
      start_layer(1, 5, 1);
      put(1, 100); put(1, 200);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      start_layer(1, 1, 1);
      chk("t7_started", busy, 1);
      q1.push_back(9); put(1, 9);
      in_valid = 1'b0;
      wait_done(1, "t7");
      chk("t7_overrun", overrun, 0);
      chk("t7_sat", sat, 0);
      chk("t7_sb_empty", q1.size(), 0);

      // Start with a zero field is ignored
      start_layer(1, 0, 3);
      chk("t8_busy_terms0", busy, 0);
      put(1, 5); put(1, 6);
      start_layer(1, 3, 0);
      chk("t8_busy_neurons0", busy, 0);
      put(1, 5); put(1, 6); put(1, 7);
      in_valid = 1'b0;
      cycle();
      chk("t8_out_valid", out_valid, 0);
      chk("t8_done", done, 0);
      chk("t8_busy", busy, 0);
      chk("final_sb_empty", q1.size() + q2.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
